// File: rtl/gate_bist_controller.sv
// gate_bist_controller
//
// Self-test sequencer for the two-input basic-gate stage (OR/AND/NOR/NAND/
// XOR/XNOR/NOT outputs A..G). It walks {x,y} through 00,01,10,11. Each
// vector is driven, allowed to settle for SETTLE_CYCLES cycles, and then the
// seven gate outputs are compared against a golden truth table. The block
// reports per-vector fail flags, an error count and a pass/done status.
//
// Timing: the edge that accepts start is E0. With all four vectors run,
// done is high 4*(SETTLE_CYCLES+2) edges after E0.
//
// Optional build macro: GATE_BIST_STOP_ON_FAIL_EN
//   Defined:   the first mismatching vector ends the pass straight away.
//   Undefined: all four vectors always run (default).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin one pass; only sampled in IDLE
//   x_out      out  x input of the gate stage
//   y_out      out  y input of the gate stage
//   gate_in    in   [6:0] gate outputs {G,F,E,D,C,B,A}
//   busy       out  pass in progress (DRIVE/SETTLE/CHECK)
//   done       out  one-cycle pulse when a pass completes
//   pass       out  no vector failed; valid at done, held until next start
//   err_count  out  [2:0] number of failing vectors
//   fail_vec   out  [3:0] bit i set if vector {x,y}=i mismatched
module gate_bist_controller #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x_out,
  output logic       y_out,
  input  logic [6:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 and counts down to zero, so
  // SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       x_q, x_d;
  logic       y_q, y_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  logic [6:0] expected;
  logic       mismatch;
  logic       vx, vy;

  // Golden truth table for the vector currently applied to the stage.
  always_comb begin
    vx       = idx_q[1];
    vy       = idx_q[0];
    expected = {~vx, ~(vx ^ vy), vx ^ vy, ~(vx & vy), ~(vx | vy), vx & vy, vx | vy};
    mismatch = (gate_in != expected);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 3'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = SettleLoad;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          fail_d[idx_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        if (mismatch || idx_q == 2'd3) begin
`else
        if (idx_q == 2'd3) begin
`endif
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = DRIVE;
        end
        // pass is decided from the count including this final check.
        if (state_d == DONE) begin
          pass_d = (err_d == 3'd0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The stage inputs are updated on the edge that enters DRIVE, so the new
    // vector is stable through DRIVE, SETTLE and CHECK.
    if (state_d == DRIVE) begin
      x_d = idx_d[1];
      y_d = idx_d[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_bist_controller.sv
// Testbench for gate_bist_controller: a behavioural gate stage with
// injectable faults, a table of fault scenarios, and a scoreboard of
// expected results checked whenever done pulses.
module tb_gate_bist_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       x_out;
  logic       y_out;
  logic [6:0] gate_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  gate_bist_controller #(.SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_out    (x_out),
    .y_out    (y_out),
    .gate_in  (gate_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Gate stage model with fault injection: AND mask forces bits low,
  // per-vector flip patterns corrupt individual vectors.
  logic [6:0]  and_mask = 7'h7f;
  logic [27:0] flips = 28'd0;
  logic [6:0]  good;
  logic [1:0]  cur_v;
  always_comb begin
    good[0] = x_out | y_out;
    good[1] = x_out & y_out;
    good[2] = !(x_out | y_out);
    good[3] = !(x_out & y_out);
    good[4] = x_out ^ y_out;
    good[5] = (x_out == y_out);
    good[6] = !x_out;
    cur_v   = {x_out, y_out};
    gate_in = (good & and_mask) ^ flips[7*cur_v +: 7];
  end

  typedef struct {
    logic [6:0]  and_mask;
    logic [27:0] flips;
    logic [2:0]  err;
    logic [3:0]  fvec;
    logic        pass;
    int          lat;
  } vec_t;

  typedef struct {
    logic [2:0] err;
    logic [3:0] fvec;
    logic       pass;
    int         at;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("err_count", {29'd0, err_count}, {29'd0, e.err});
        chk("fail_vec", {28'd0, fail_vec}, {28'd0, e.fvec});
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic push_exp(input vec_t v, input int at);
    exp_t e;
    e.err  = v.err;
    e.fvec = v.fvec;
    e.pass = v.pass;
    e.at   = at;
    sbq.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      chk(name, 32'd1, 32'd0);
      sbq.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int e0;
    int rel;
    and_mask = v.and_mask;
    flips    = v.flips;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    e0    = cyc;
    start = 1'b0;
    push_exp(v, e0 + v.lat);
    chk({tag, "_cleared"}, {25'd0, busy, pass, err_count, fail_vec}, {25'd0, 1'b1, 1'b0, 3'd0, 4'd0});
    for (int n = 0; n < 60; n++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
      rel = cyc - e0;
      if (rel % 4 == 2 && rel < v.lat) begin
        chk({tag, "_xy"}, {30'd0, x_out, y_out}, 32'(rel / 4));
      end
    end
    wait_drain({tag, "_timeout"}, 2);
  endtask

  initial begin
    vec_t ok;
    int   e0;
    // and_mask, flips, err, fail_vec, pass, latency
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    tbl[0] = '{7'h7f, 28'd0, 3'd0, 4'b0000, 1'b1, 16};
    tbl[1] = '{7'h6f, 28'd0, 3'd1, 4'b0010, 1'b0, 8};
    tbl[2] = '{7'h00, 28'd0, 3'd1, 4'b0001, 1'b0, 4};
    tbl[3] = '{7'h7f, {7'h02, 7'h00, 7'h00, 7'h00}, 3'd1, 4'b1000, 1'b0, 16};
    tbl[4] = '{7'h7f, {7'h00, 7'h00, 7'h00, 7'h40}, 3'd1, 4'b0001, 1'b0, 4};
    tbl[5] = '{7'h7f, {7'h20, 7'h01, 7'h00, 7'h00}, 3'd1, 4'b0100, 1'b0, 12};
`else
    tbl[0] = '{7'h7f, 28'd0, 3'd0, 4'b0000, 1'b1, 16};
    tbl[1] = '{7'h6f, 28'd0, 3'd2, 4'b0110, 1'b0, 16};
    tbl[2] = '{7'h00, 28'd0, 3'd4, 4'b1111, 1'b0, 16};
    tbl[3] = '{7'h7f, {7'h02, 7'h00, 7'h00, 7'h00}, 3'd1, 4'b1000, 1'b0, 16};
    tbl[4] = '{7'h7f, {7'h00, 7'h00, 7'h00, 7'h40}, 3'd1, 4'b0001, 1'b0, 16};
    tbl[5] = '{7'h7f, {7'h20, 7'h01, 7'h00, 7'h00}, 3'd2, 4'b1100, 1'b0, 16};
`endif
    ok = tbl[0];

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {22'd0, x_out, y_out, busy, done, pass, err_count, fail_vec},
        32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Reset during the SETTLE of vector 2 aborts the pass at once.
    and_mask = 7'h7f;
    flips    = 28'd0;
    start    = 1'b1;
    @(negedge clk);
    e0    = cyc;
    start = 1'b0;
    push_exp(ok, e0 + 16);
    while (cyc - e0 < 9) @(negedge clk);
    chk("pre_rst_x", {31'd0, x_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_pass", {22'd0, x_out, y_out, busy, done, pass, err_count, fail_vec},
        32'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    run_vec(ok, "after_rst");

    // start pulses while busy and while in DONE are ignored.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    e0    = cyc;
    start = 1'b0;
    push_exp(ok, e0 + 16);
    while (cyc - e0 < 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - e0 < 16) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    wait_drain("repulse_timeout", 1);
    chk("repulse_idle", {31'd0, busy}, 32'd0);

    // start held high: a second pass begins on the edge after DONE->IDLE.
    start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    push_exp(ok, e0 + 16);
    push_exp(ok, e0 + 34);
    while (cyc - e0 < 34) @(negedge clk);
    start = 1'b0;
    wait_drain("held_timeout", 4);
    repeat (6) @(negedge clk);
    chk("held_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
